lsu_ctrl: RTL and testbench

//  Load/store sequencer on the initiator side of the DCache port. Accepts one memory

---
 rtl/lsu_ctrl_pkg.sv | 41 ++++
 rtl/lsu_prio_enc.sv | 20 ++
 rtl/lsu_ctrl.sv | 131 +++++++++++++
 tb/tb_lsu_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: DCache micro-op codes,
// request op codes and FSM state encoding.
package lsu_ctrl_pkg;

  // DCache micro-ops; the DCache decodes the same constants.
  localparam logic [4:0] UOP_NONE = 5'b00000;
  localparam logic [4:0] UOP_STR  = 5'b01001;
  localparam logic [4:0] UOP_LDR  = 5'b01010;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    OpLdr = 2'd0,
    OpStr = 2'd1,
    OpLdm = 2'd2,
    OpStm = 2'd3
  } lsu_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWait   = 2'd2,
    StDone   = 2'd3
  } lsu_state_e;

  function automatic logic op_is_store(lsu_op_e op);
    return (op == OpStr) || (op == OpStm);
  endfunction

  function automatic logic op_is_single(lsu_op_e op);
    return (op == OpLdr) || (op == OpStr);
  endfunction

  // Single-word ops become a one-entry register list so LDR/STR share the LDM/STM path.
  function automatic logic [15:0] op_mask(lsu_op_e op, logic [3:0] rd, logic [15:0] reglist);
    logic [15:0] one;
    one = 16'd1;
    return op_is_single(op) ? (one << rd) : reglist;
  endfunction

endpackage

// File: rtl/lsu_prio_enc.sv
// Lowest-set-bit encoder for a 16-bit register mask.
module lsu_prio_enc (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        any
);

  always_comb begin
    idx = '0;
    // Scan downwards so the lowest set bit is the last to win.
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 4'(i);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer driving the DCache port: LDR/STR single words and LDM/STM
// register-list transfers in ascending register/address order, increment-after.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [3:0]        req_rd,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [15:0]       req_reglist,
  output logic [3:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_data_in,
  output logic [4:0]        dc_uop,
  input  logic [DATA_W-1:0] dc_data_out,
  output logic              wb_valid,
  output logic [3:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic [ADDR_W-1:0] base_wb
);

  lsu_state_e        state_q;
  logic [15:0]       mask_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic              store_q;
  logic              single_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] dc_addr_q;
  logic [DATA_W-1:0] dc_data_q;
  logic [ADDR_W-1:0] base_wb_q;

  logic [3:0]        cur_reg;
  logic              mask_any;
  logic [15:0]       mask_rest;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] store_data;
  lsu_op_e           op_in;
  logic [15:0]       new_mask;

  lsu_prio_enc u_prio_enc (
    .mask (mask_q),
    .idx  (cur_reg),
    .any  (mask_any)
  );

  assign op_in      = lsu_op_e'(req_op);
  assign new_mask   = op_mask(op_in, req_rd, req_reglist);
  // Clearing the lowest set bit retires exactly the current register.
  assign mask_rest  = mask_q & (mask_q - 16'd1);
  assign next_addr  = cur_addr_q + ADDR_W'(WORD_BYTES);
  assign store_data = single_q ? wdata_q : rf_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      cur_addr_q <= '0;
      store_q    <= 1'b0;
      single_q   <= 1'b0;
      wdata_q    <= '0;
      dc_addr_q  <= '0;
      dc_data_q  <= '0;
      base_wb_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            mask_q     <= new_mask;
            cur_addr_q <= req_base & ~ADDR_W'(3);
            store_q    <= op_is_store(op_in);
            single_q   <= op_is_single(op_in);
            wdata_q    <= req_wdata;
            state_q    <= (new_mask == '0) ? StDone : StAccess;
          end
        end
        StAccess: begin
          dc_addr_q <= cur_addr_q;
          if (store_q) begin
            dc_data_q  <= store_data;
            mask_q     <= mask_rest;
            cur_addr_q <= next_addr;
            state_q    <= (mask_rest == '0) ? StDone : StAccess;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          mask_q     <= mask_rest;
          cur_addr_q <= next_addr;
          state_q    <= (mask_rest == '0) ? StDone : StAccess;
        end
        StDone: begin
          base_wb_q <= cur_addr_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Store data must be combinational here: rf_rdata answers rf_raddr in the same cycle.
  always_comb begin
    req_ready  = (state_q == StIdle) && !reset;
    rf_raddr   = cur_reg;
    dc_uop     = UOP_NONE;
    dc_addr    = dc_addr_q;
    dc_data_in = dc_data_q;
    if (state_q == StAccess && mask_any) begin
      dc_uop  = store_q ? UOP_STR : UOP_LDR;
      dc_addr = cur_addr_q;
      if (store_q) begin
        dc_data_in = store_data;
      end
    end
    wb_valid = (state_q == StWait);
    wb_reg   = cur_reg;
    wb_data  = dc_data_out;
    done     = (state_q == StDone);
    base_wb  = done ? cur_addr_q : base_wb_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural DCache and register file.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_base;
  logic [3:0]  req_rd;
  logic [31:0] req_wdata;
  logic [15:0] req_reglist;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] dc_addr;
  logic [31:0] dc_data_in;
  logic [4:0]  dc_uop;
  logic [31:0] dc_data_out;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        done;
  logic [31:0] base_wb;

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  logic [31:0] rf [16];
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  logic [63:0] exp_st [$];
  logic [31:0] exp_ld [$];
  logic [35:0] exp_wb [$];
  logic [31:0] exp_done [$];

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_base    (req_base),
    .req_rd      (req_rd),
    .req_wdata   (req_wdata),
    .req_reglist (req_reglist),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .dc_addr     (dc_addr),
    .dc_data_in  (dc_data_in),
    .dc_uop      (dc_uop),
    .dc_data_out (dc_data_out),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .done        (done),
    .base_wb     (base_wb)
  );

  always #5 clock = ~clock;

  assign rf_rdata = rf[rf_raddr];

  // DCache model: write on UOP_STR, read data one cycle after UOP_LDR.
  always @(posedge clock) begin
    if (dc_uop == UOP_STR) begin
      dmem[dc_addr] = dc_data_in;
    end
    if (dc_uop == UOP_LDR) begin
      dc_data_out <= dmem.exists(dc_addr) ? dmem[dc_addr] : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // Monitor: pops an expectation for every event the DUT presents.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (dc_uop == UOP_STR) begin
          if (exp_st.size() == 0) unexpected("store");
          else chk("store_addr_data", {dc_addr, dc_data_in}, exp_st.pop_front());
        end else if (dc_uop == UOP_LDR) begin
          if (exp_ld.size() == 0) unexpected("load");
          else chk("load_addr", {32'h0, dc_addr}, {32'h0, exp_ld.pop_front()});
        end else if (dc_uop != UOP_NONE) begin
          chk("uop_code", {59'h0, dc_uop}, {59'h0, UOP_NONE});
        end
        if (wb_valid) begin
          if (exp_wb.size() == 0) unexpected("writeback");
          else chk("wb_reg_data", {28'h0, wb_reg, wb_data}, {28'h0, exp_wb.pop_front()});
        end
        if (done) begin
          if (exp_done.size() == 0) unexpected("done");
          else chk("base_wb", {32'h0, base_wb}, {32'h0, exp_done.pop_front()});
        end
      end
    end
  end

  // Expected events: ascending registers, word-aligned increment-after addresses.
  task automatic plan(input lsu_op_e op, input logic [31:0] base, input logic [3:0] rd,
                      input logic [31:0] wdata, input logic [15:0] list,
                      input logic [31:0] exp_bw);
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] m;
    a = {base[31:2], 2'b00};
    m = list;
    if (op == OpLdr || op == OpStr) begin
      m = '0;
      m[rd] = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        if (op == OpStr || op == OpStm) begin
          d = (op == OpStr) ? wdata : rf[i];
          exp_st.push_back({a, d});
          ref_mem[a] = d;
        end else begin
          exp_ld.push_back(a);
          d = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
          exp_wb.push_back({4'(i), d});
        end
        a = a + 32'd4;
      end
    end
    exp_done.push_back(exp_bw);
  endtask

  // Holds req_valid until the handshake edge; returns just after that edge.
  task automatic send(input lsu_op_e op, input logic [31:0] base, input logic [3:0] rd,
                      input logic [31:0] wdata, input logic [15:0] list);
    bit ok;
    @(posedge clock);
    #1;
    req_valid   = 1'b1;
    req_op      = op;
    req_base    = base;
    req_rd      = rd;
    req_wdata   = wdata;
    req_reglist = list;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) unexpected("handshake_timeout");
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input lsu_op_e op, input logic [31:0] base, input logic [3:0] rd,
                         input logic [31:0] wdata, input logic [15:0] list,
                         input logic [31:0] exp_bw, input int exp_lat);
    int lat;
    plan(op, base, rd, wdata, list, exp_bw);
    send(op, base, rd, wdata, list);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", 64'(lat), 64'(exp_lat));
    @(negedge clock);
    chk("ready_after_done", {63'h0, req_ready}, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_op      = '0;
    req_base    = '0;
    req_rd      = '0;
    req_wdata   = '0;
    req_reglist = '0;
    dc_data_out = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'hDEAD_0000 | 32'(i);
    rf[0]  = 32'hB0;
    rf[1]  = 32'hA1;
    rf[2]  = 32'hA2;
    rf[15] = 32'hAF;

    repeat (3) @(negedge clock);
    chk("ready_in_reset", {63'h0, req_ready}, 64'h0);
    chk("reset_uop", {59'h0, dc_uop}, {59'h0, UOP_NONE});
    chk("reset_addr", {32'h0, dc_addr}, 64'h0);
    chk("reset_data_in", {32'h0, dc_data_in}, 64'h0);
    chk("reset_wb_done", {62'h0, wb_valid, done}, 64'h0);
    chk("reset_base_wb", {32'h0, base_wb}, 64'h0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", {63'h0, req_ready}, 64'h1);

    // 1: STR then LDR of the same word.
    run_req(OpStr, 32'h28, 4'd0, 32'h1234_5678, 16'h0, 32'h2C, 2);
    run_req(OpLdr, 32'h28, 4'd3, 32'h0, 16'h0, 32'h2C, 3);
    // 2/3: STM and LDM of R1, R2, R15.
    run_req(OpStm, 32'h100, 4'd0, 32'h0, 16'h8006, 32'h10C, 4);
    run_req(OpLdm, 32'h100, 4'd0, 32'h0, 16'h8006, 32'h10C, 7);
    // 4: empty list.
    run_req(OpLdm, 32'h200, 4'd0, 32'h0, 16'h0000, 32'h200, 1);
    // 5: address wrap and ignored low base bits.
    run_req(OpStm, 32'hFFFF_FFFC, 4'd0, 32'h0, 16'h0003, 32'h4, 3);
    run_req(OpLdm, 32'hFFFF_FFFC, 4'd0, 32'h0, 16'h0003, 32'h4, 5);
    run_req(OpStr, 32'h103, 4'd0, 32'hCAFE_F00D, 16'h0, 32'h104, 2);
    run_req(OpLdr, 32'h102, 4'd7, 32'h0, 16'h0, 32'h104, 3);

    // 6: reset in the second ACCESS of a 4-register LDM.
    exp_ld.push_back(32'h104);
    exp_wb.push_back({4'd0, 32'hA2});
    send(OpLdm, 32'h104, 4'd0, 32'h0, 16'h000F);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_mid_reset", {63'h0, req_ready}, 64'h1);
    chk("uop_after_mid_reset", {59'h0, dc_uop}, {59'h0, UOP_NONE});
    repeat (6) @(negedge clock);
    chk("aborted_ld_drained", 64'(exp_ld.size() + exp_wb.size()), 64'h0);
    run_req(OpLdr, 32'h108, 4'd5, 32'h0, 16'h0, 32'h10C, 3);

    repeat (4) @(negedge clock);
    chk("stores_drained", 64'(exp_st.size()), 64'h0);
    chk("loads_drained", 64'(exp_ld.size()), 64'h0);
    chk("wbs_drained", 64'(exp_wb.size()), 64'h0);
    chk("dones_drained", 64'(exp_done.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
